mesh_router_buf: RTL

- Buffered 5-port 2D-mesh node router; successor to the unbuffered node router.
- Ports 0..3 connect to mesh neighbours, port 4 to the local neuron processing element.
- Each input has a parametrised FIFO; routing is dimension-ordered XY from a destination header; per-output round-robin arbitration; registered outputs with valid/ready handshake.
- Single-flit packets: one stream word is one complete packet.

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_fifo.sv | 48 ++++
 rtl/mesh_router_buf.sv | 107 ++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - port indices and XY route function for the buffered mesh router
package router_pkg;

    localparam int NPORTS = 5;

    localparam logic [2:0] PORT_XP    = 3'd0;
    localparam logic [2:0] PORT_XN    = 3'd1;
    localparam logic [2:0] PORT_YP    = 3'd2;
    localparam logic [2:0] PORT_YN    = 3'd3;
    localparam logic [2:0] PORT_LOCAL = 3'd4;

    // X is resolved fully before Y; an exact match on both ends at the local port.
    function automatic logic [2:0] xy_route(input int unsigned dest_x, input int unsigned dest_y,
                                            input int unsigned self_x, input int unsigned self_y);
        if (dest_x > self_x) return PORT_XP;
        if (dest_x < self_x) return PORT_XN;
        if (dest_y > self_y) return PORT_YP;
        if (dest_y < self_y) return PORT_YN;
        return PORT_LOCAL;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-input flit FIFO, no push/pop bypass
module router_fifo #(
    parameter int STREAM_W = 144,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STREAM_W-1:0] wr_data,
    input  logic                push,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output logic [STREAM_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [STREAM_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (!do_push && do_pop) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/mesh_router_buf.sv
// rtl/mesh_router_buf.sv - buffered 5-port XY mesh router with per-output round-robin
module mesh_router_buf
    import router_pkg::*;
#(
    parameter int          STREAM_W = 144,
    parameter int          COORD_W  = 2,
    parameter int          DEPTH    = 4,
    parameter int unsigned SELF_X   = 0,
    parameter int unsigned SELF_Y   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NPORTS*STREAM_W-1:0]   in_data,
    input  logic [NPORTS-1:0]            in_valid,
    output logic [NPORTS-1:0]            in_ready,
    output logic [NPORTS*STREAM_W-1:0]   out_data,
    output logic [NPORTS-1:0]            out_valid,
    input  logic [NPORTS-1:0]            out_ready
);

    logic [STREAM_W-1:0] head [NPORTS];
    logic [2:0]          route [NPORTS];
    logic [NPORTS-1:0]   full;
    logic [NPORTS-1:0]   empty;
    logic [NPORTS-1:0]   pop;
    logic [NPORTS-1:0]   gnt_oh [NPORTS];

    for (genvar i = 0; i < NPORTS; i++) begin : g_in
        assign in_ready[i] = !full[i] && !rst;

        router_fifo #(.STREAM_W(STREAM_W), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_data (in_data[i*STREAM_W +: STREAM_W]),
            .push    (in_valid[i] && in_ready[i]),
            .pop     (pop[i]),
            .full    (full[i]),
            .empty   (empty[i]),
            .head    (head[i])
        );

        assign route[i] = xy_route(32'(head[i][STREAM_W-1 -: COORD_W]),
                                   32'(head[i][STREAM_W-1-COORD_W -: COORD_W]),
                                   SELF_X, SELF_Y);
    end

    // Each head targets one output, so OR-ing the grants never pops a FIFO twice.
    always_comb begin
        pop = '0;
        for (int o = 0; o < NPORTS; o++) pop = pop | gnt_oh[o];
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        logic [NPORTS-1:0]   req;
        logic                slot_free;
        logic                gnt;
        logic [2:0]          gnt_idx;
        logic [2:0]          rr_ptr;
        logic [STREAM_W-1:0] out_q;
        logic                out_v;

        for (genvar i = 0; i < NPORTS; i++) begin : g_req
            assign req[i] = !empty[i] && (route[i] == 3'(o));
        end

        assign slot_free = !out_v || out_ready[o];

        always_comb begin
            logic [3:0] sum;
            logic [2:0] idx;
            gnt     = 1'b0;
            gnt_idx = '0;
            sum     = '0;
            idx     = '0;
            for (int k = 0; k < NPORTS; k++) begin
                sum = {1'b0, rr_ptr} + 4'(k);
                idx = (sum >= 4'(NPORTS)) ? 3'(sum - 4'(NPORTS)) : sum[2:0];
                if (slot_free && !gnt && req[idx]) begin
                    gnt     = 1'b1;
                    gnt_idx = idx;
                end
            end
        end

        assign gnt_oh[o] = gnt ? (NPORTS'(1) << gnt_idx) : '0;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_q  <= '0;
                out_v  <= 1'b0;
                rr_ptr <= '0;
            end else if (slot_free) begin
                if (gnt) begin
                    out_q  <= head[gnt_idx];
                    out_v  <= 1'b1;
                    rr_ptr <= (gnt_idx == 3'(NPORTS-1)) ? 3'd0 : gnt_idx + 3'd1;
                end else begin
                    out_v  <= 1'b0;
                end
            end
        end

        assign out_data[o*STREAM_W +: STREAM_W] = out_q;
        assign out_valid[o] = out_v;
    end

endmodule
